io_channel_initiator: RTL and testbench

IO_CHANNEL_INITIATOR -- requirements
Module: io_channel_initiator

---
 rtl/io_channel_initiator.sv | 128 ++++++++++++
 tb/tb_io_channel_initiator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/io_channel_initiator.sv
// io_channel_initiator: issues CPU commands to an IO module and writes register responses back to the CPU
//
// Ports:
//   clk, sync_rst_n (sync, active-low), clk_en (low freezes all state)
//   CPU command   : CommandREQ/CommandACK, MinorOpcodeIn, CommandDataIn, CommandDestReg
//   CPU writeback : WritebackREQ/WritebackACK, WritebackDestReg, WritebackDataOut
//   IO command    : IO_REQ/IO_ACK, IO_CommandEn, IO_ResponseRequested, IO_MinorOpcodeOut, IO_DestRegOut, IO_DataOut
//   IO response   : IO_CommandResponse, IO_RegResponseFlag, IO_MemResponseFlag, IO_DestRegIn, IO_DataIn
//   Status        : Busy, DroppedResponse (sticky), TimeoutFlag (sticky)
//
// Optional feature: define IO_RESPONSE_TIMEOUT_EN to bound WAIT_RESP to TIMEOUTCYCLES enabled cycles.
module io_channel_initiator #(
    parameter int DATABITWIDTH  = 16,
    parameter int TIMEOUTCYCLES = 255
) (
    input  logic                    clk,
    input  logic                    sync_rst_n,
    input  logic                    clk_en,
    input  logic                    CommandREQ,
    output logic                    CommandACK,
    input  logic [3:0]              MinorOpcodeIn,
    input  logic [DATABITWIDTH-1:0] CommandDataIn,
    input  logic [3:0]              CommandDestReg,
    output logic                    WritebackREQ,
    input  logic                    WritebackACK,
    output logic [3:0]              WritebackDestReg,
    output logic [DATABITWIDTH-1:0] WritebackDataOut,
    output logic                    IO_REQ,
    input  logic                    IO_ACK,
    output logic                    IO_CommandEn,
    output logic                    IO_ResponseRequested,
    output logic [3:0]              IO_MinorOpcodeOut,
    output logic [3:0]              IO_DestRegOut,
    output logic [DATABITWIDTH-1:0] IO_DataOut,
    input  logic                    IO_CommandResponse,
    input  logic                    IO_RegResponseFlag,
    input  logic                    IO_MemResponseFlag,
    input  logic [3:0]              IO_DestRegIn,
    input  logic [DATABITWIDTH-1:0] IO_DataIn,
    output logic                    Busy,
    output logic                    DroppedResponse,
    output logic                    TimeoutFlag
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, WRITEBACK} state_t;
    state_t state;

    // A memory-only response needs no writeback, so the mem flag carries no extra information.
    logic unused_cfg;
`ifdef IO_RESPONSE_TIMEOUT_EN
    logic [15:0] count;
    assign unused_cfg = IO_MemResponseFlag;
`else
    assign TimeoutFlag = 1'b0;
    assign unused_cfg  = IO_MemResponseFlag ^ 1'(TIMEOUTCYCLES);
`endif

    // Held low during reset so the CPU never sees an accept before the first idle cycle.
    assign CommandACK = sync_rst_n && state == IDLE;
    assign Busy       = state != IDLE;

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state                <= IDLE;
            WritebackREQ         <= 1'b0;
            WritebackDestReg     <= '0;
            WritebackDataOut     <= '0;
            IO_REQ               <= 1'b0;
            IO_CommandEn         <= 1'b0;
            IO_ResponseRequested <= 1'b0;
            IO_MinorOpcodeOut    <= '0;
            IO_DestRegOut        <= '0;
            IO_DataOut           <= '0;
            DroppedResponse      <= 1'b0;
`ifdef IO_RESPONSE_TIMEOUT_EN
            TimeoutFlag          <= 1'b0;
            count                <= '0;
`endif
        end else if (clk_en) begin
            // Only WAIT_RESP consumes responses, including one coincident with IO_ACK.
            if (IO_CommandResponse && state != WAIT_RESP)
                DroppedResponse <= 1'b1;
            case (state)
                IDLE: if (CommandREQ) begin
                    IO_MinorOpcodeOut    <= MinorOpcodeIn;
                    IO_DataOut           <= CommandDataIn;
                    IO_DestRegOut        <= CommandDestReg;
                    IO_ResponseRequested <= ~MinorOpcodeIn[3];
                    IO_REQ               <= 1'b1;
                    IO_CommandEn         <= 1'b1;
                    state                <= ISSUE;
                end
                ISSUE: if (IO_ACK) begin
                    IO_REQ       <= 1'b0;
                    IO_CommandEn <= 1'b0;
                    state        <= IO_ResponseRequested ? WAIT_RESP : IDLE;
`ifdef IO_RESPONSE_TIMEOUT_EN
                    count        <= '0;
`endif
                end
                WAIT_RESP: if (IO_CommandResponse) begin
                    if (IO_RegResponseFlag) begin
                        WritebackDataOut <= IO_DataIn;
                        WritebackDestReg <= IO_DestRegIn;
                        WritebackREQ     <= 1'b1;
                        state            <= WRITEBACK;
                    end else
                        state <= IDLE;
                end
`ifdef IO_RESPONSE_TIMEOUT_EN
                // The response check above has priority, so a reply on the final cycle wins.
                else if (count == 16'(TIMEOUTCYCLES - 1)) begin
                    WritebackDataOut <= '1;
                    WritebackDestReg <= IO_DestRegOut;
                    WritebackREQ     <= 1'b1;
                    TimeoutFlag      <= 1'b1;
                    state            <= WRITEBACK;
                end else
                    count <= count + 16'd1;
`endif
                WRITEBACK: if (WritebackACK) begin
                    WritebackREQ <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_channel_initiator.sv
// tb_io_channel_initiator: directed self-checking bench for io_channel_initiator
module tb_io_channel_initiator;
    logic        clk = 0, sync_rst_n = 0, clk_en = 1;
    logic        CommandREQ = 0, WritebackACK = 0, IO_ACK = 0;
    logic        IO_CommandResponse = 0, IO_RegResponseFlag = 0, IO_MemResponseFlag = 0;
    logic [3:0]  MinorOpcodeIn = 0, CommandDestReg = 0, IO_DestRegIn = 0;
    logic [15:0] CommandDataIn = 0, IO_DataIn = 0;
    logic        CommandACK, WritebackREQ, IO_REQ, IO_CommandEn, IO_ResponseRequested;
    logic        Busy, DroppedResponse, TimeoutFlag;
    logic [3:0]  WritebackDestReg, IO_MinorOpcodeOut, IO_DestRegOut;
    logic [15:0] WritebackDataOut, IO_DataOut;
    int          compared = 0, mismatched = 0;

    io_channel_initiator #(.DATABITWIDTH(16), .TIMEOUTCYCLES(4)) dut (
        .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en),
        .CommandREQ(CommandREQ), .CommandACK(CommandACK), .MinorOpcodeIn(MinorOpcodeIn),
        .CommandDataIn(CommandDataIn), .CommandDestReg(CommandDestReg),
        .WritebackREQ(WritebackREQ), .WritebackACK(WritebackACK),
        .WritebackDestReg(WritebackDestReg), .WritebackDataOut(WritebackDataOut),
        .IO_REQ(IO_REQ), .IO_ACK(IO_ACK), .IO_CommandEn(IO_CommandEn),
        .IO_ResponseRequested(IO_ResponseRequested), .IO_MinorOpcodeOut(IO_MinorOpcodeOut),
        .IO_DestRegOut(IO_DestRegOut), .IO_DataOut(IO_DataOut),
        .IO_CommandResponse(IO_CommandResponse), .IO_RegResponseFlag(IO_RegResponseFlag),
        .IO_MemResponseFlag(IO_MemResponseFlag), .IO_DestRegIn(IO_DestRegIn), .IO_DataIn(IO_DataIn),
        .Busy(Busy), .DroppedResponse(DroppedResponse), .TimeoutFlag(TimeoutFlag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a load to dest d, acknowledge it, and leave the DUT in WAIT_RESP.
    task automatic enter_wait(input logic [3:0] d);
        CommandREQ = 1; MinorOpcodeIn = 4'h2; CommandDestReg = d; CommandDataIn = 16'h0;
        step();
        CommandREQ = 0; IO_ACK = 1;
        step();
        IO_ACK = 0;
        chk("enter_wait_busy", Busy, 1);
        chk("enter_wait_ioreq", IO_REQ, 0);
    endtask

    initial begin
        step();
        chk("rst_cmdack", CommandACK, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_ioreq", IO_REQ, 0);
        chk("rst_wbreq", WritebackREQ, 0);
        chk("rst_dropped", DroppedResponse, 0);
        chk("rst_timeout", TimeoutFlag, 0);
        sync_rst_n = 1;
        #1;
        chk("idle_cmdack", CommandACK, 1);

        // Load: opcode 2, dest 5, IO_ACK two cycles after issue
        CommandREQ = 1; MinorOpcodeIn = 4'h2; CommandDestReg = 4'd5; CommandDataIn = 16'hA5A5;
        step();
        CommandREQ = 0;
        chk("ld_ioreq", IO_REQ, 1);
        chk("ld_cmden", IO_CommandEn, 1);
        chk("ld_respreq", IO_ResponseRequested, 1);
        chk("ld_opcode", IO_MinorOpcodeOut, 4'h2);
        chk("ld_dest", IO_DestRegOut, 4'd5);
        chk("ld_cmdack", CommandACK, 0);
        step(); step();
        chk("ld_hold_ioreq", IO_REQ, 1);
        chk("ld_hold_data", IO_DataOut, 16'hA5A5);
        IO_ACK = 1;
        step();
        IO_ACK = 0;
        chk("ld_ioreq_drop", IO_REQ, 0);
        chk("ld_cmden_drop", IO_CommandEn, 0);
        step();
        chk("ld_wait_wb", WritebackREQ, 0);
        IO_CommandResponse = 1; IO_RegResponseFlag = 1; IO_DataIn = 16'h1234; IO_DestRegIn = 4'd5;
        step();
        IO_CommandResponse = 0; IO_RegResponseFlag = 0; IO_DataIn = 16'h0; IO_DestRegIn = 4'd0;
        chk("ld_wbreq", WritebackREQ, 1);
        chk("ld_wbdata", WritebackDataOut, 16'h1234);
        chk("ld_wbdest", WritebackDestReg, 4'd5);
        chk("ld_nodrop", DroppedResponse, 0);

        // Writeback withheld for 10 cycles with clk_en toggling; responses while frozen are ignored
        for (int i = 0; i < 10; i++) begin
            clk_en = i[0];
            IO_CommandResponse = ~i[0];
            step();
            chk("wb_hold_req", WritebackREQ, 1);
            chk("wb_hold_data", WritebackDataOut, 16'h1234);
            chk("wb_hold_cmdack", CommandACK, 0);
            chk("wb_hold_dropped", DroppedResponse, 0);
        end
        clk_en = 1; IO_CommandResponse = 0;
        WritebackACK = 1;
        clk_en = 0;
        step();
        chk("wb_frozen_ack", WritebackREQ, 1);
        clk_en = 1;
        step();
        WritebackACK = 0;
        chk("wb_done_req", WritebackREQ, 0);
        chk("wb_done_cmdack", CommandACK, 1);
        chk("wb_done_busy", Busy, 0);

        // Store: opcode 9, data BEEF, immediate IO_ACK
        CommandREQ = 1; MinorOpcodeIn = 4'h9; CommandDataIn = 16'hBEEF; CommandDestReg = 4'd3;
        step();
        CommandREQ = 0; IO_ACK = 1;
        chk("st_data", IO_DataOut, 16'hBEEF);
        chk("st_respreq", IO_ResponseRequested, 0);
        chk("st_ioreq", IO_REQ, 1);
        step();
        IO_ACK = 0;
        chk("st_ioreq_drop", IO_REQ, 0);
        chk("st_idle", Busy, 0);
        chk("st_cmdack", CommandACK, 1);
        step();
        chk("st_no_wb", WritebackREQ, 0);

        // Memory-only response: consumed with no writeback
        enter_wait(4'd6);
        IO_CommandResponse = 1; IO_RegResponseFlag = 0; IO_MemResponseFlag = 1;
        step();
        IO_CommandResponse = 0; IO_MemResponseFlag = 0;
        chk("mem_idle", Busy, 0);
        chk("mem_no_wb", WritebackREQ, 0);
        chk("mem_nodrop", DroppedResponse, 0);

`ifdef IO_RESPONSE_TIMEOUT_EN
        // Response on the fourth waiting cycle beats the timeout
        enter_wait(4'd7);
        step(); step(); step();
        chk("to_race_wait", WritebackREQ, 0);
        IO_CommandResponse = 1; IO_RegResponseFlag = 1; IO_DataIn = 16'h55AA; IO_DestRegIn = 4'd7;
        step();
        IO_CommandResponse = 0; IO_RegResponseFlag = 0;
        chk("to_race_wbreq", WritebackREQ, 1);
        chk("to_race_data", WritebackDataOut, 16'h55AA);
        chk("to_race_flag", TimeoutFlag, 0);
        WritebackACK = 1;
        step();
        WritebackACK = 0;
        // No response: timeout after four waiting cycles
        enter_wait(4'd7);
        step(); step(); step();
        chk("to_wait", WritebackREQ, 0);
        step();
        chk("to_wbreq", WritebackREQ, 1);
        chk("to_data", WritebackDataOut, 16'hFFFF);
        chk("to_dest", WritebackDestReg, 4'd7);
        chk("to_flag", TimeoutFlag, 1);
        WritebackACK = 1;
        step();
        WritebackACK = 0;
        chk("to_idle", Busy, 0);
`else
        // Without the timeout the wait is unbounded
        enter_wait(4'd7);
        for (int i = 0; i < 20; i++) step();
        chk("nto_busy", Busy, 1);
        chk("nto_wbreq", WritebackREQ, 0);
        chk("nto_flag", TimeoutFlag, 0);
        sync_rst_n = 0;
        step();
        sync_rst_n = 1;
`endif

        // Reset during WAIT_RESP abandons the transaction; the late response is dropped
        enter_wait(4'd9);
        sync_rst_n = 0; clk_en = 0;
        step();
        chk("mrst_cmdack", CommandACK, 0);
        chk("mrst_busy", Busy, 0);
        chk("mrst_ioreq", IO_REQ, 0);
        chk("mrst_iodest", IO_DestRegOut, 0);
        chk("mrst_opcode", IO_MinorOpcodeOut, 0);
        chk("mrst_wbreq", WritebackREQ, 0);
        chk("mrst_wbdata", WritebackDataOut, 0);
        chk("mrst_flag", TimeoutFlag, 0);
        sync_rst_n = 1; clk_en = 1;
        #1;
        chk("mrst_release_ack", CommandACK, 1);
        IO_CommandResponse = 1; IO_RegResponseFlag = 1; IO_DataIn = 16'h4321; IO_DestRegIn = 4'd9;
        step();
        IO_CommandResponse = 0; IO_RegResponseFlag = 0;
        chk("late_dropped", DroppedResponse, 1);
        chk("late_no_wb", WritebackREQ, 0);
        step(); step(); step();
        chk("sticky_dropped", DroppedResponse, 1);
        chk("sticky_no_wb", WritebackREQ, 0);
        chk("sticky_idle", CommandACK, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
